stc_max_n: RTL and testbench
============================

Name: stc_max_n

Overview:
- N-input temporal MAX for space-time computing (race logic) on pulse-coded spike lines.
- Each input carries at most one event per gamma cycle, marked by a rising edge.
- Output spike fires once all enabled inputs have fired in the current gamma cycle, i.e. at the latest arrival time.
- Sits in the column/neuron datapath beside the 2-input max; driven by the shared gamma-start strobe; reports the spike and its arrival time.

Parameters:
- N_INPUTS, 4, number of spike inputs (>=1).
- GAMMA_CYCLE_WIDTH, 16, aclk cycles per gamma cycle; sets the phase counter range.
- PULSE_WIDTH, 8, output pulse length in aclk cycles in pulse mode (>=1).
- OUT_MODE, MODE_PULSE, MODE_PULSE = fixed-width pulse; MODE_LEVEL = y held high until next gamma_start.

Ports:
- aclk  in  1  clock
- grst  in  1  asynchronous active-high reset
- gamma_start  in  1  single-cycle strobe marking the first cycle of a gamma cycle
- in_mask  in  N_INPUTS  1 = channel participates; sampled every cycle
- a  in  N_INPUTS  spike inputs, edge-coded
- y  out  1  output spike
- spike_valid  out  1  high from fire until next gamma_start
- spike_time  out  $clog2(GAMMA_CYCLE_WIDTH)  gamma phase of the firing (latest) arrival
- busy  out  1  high while in WAIT state

Behaviour:
- Reset: grst is asynchronous, active-high; clock is aclk. Reset clears y=0, spike_valid=0, spike_time=0, busy=0, arrived=0, prev=0, phase=0, state=IDLE.
- Phase:
  - cur_phase = gamma_start ? 0 : phase_q.
  - phase_q <= min(cur_phase+1, GAMMA_CYCLE_WIDTH-1), saturating.
- Edge detect:
  - rise[i] = a[i] & ~prev[i]; prev <= a every cycle.
  - prev is not cleared by gamma_start, so a level held high across gamma_start is not a new event.
- Arrival latch:
  - arrived[i] <= (gamma_start ? 0 : arrived[i]) | rise[i].
  - An edge in the same cycle as gamma_start belongs to the new gamma cycle with time 0.
- all_in = &(arrived_next | ~in_mask) & (|in_mask). If all inputs are masked, the block never fires.
- FSM:
  - IDLE: leaves only on gamma_start, to WAIT (or directly to FIRE if all_in in the same cycle).
  - WAIT, busy=1: when all_in, go to FIRE and latch spike_time=cur_phase. The time is that of the cycle that completed the set, i.e. the max arrival.
  - FIRE: y=1, registered. y first rises at posedge k+1, where k is the completing sample.
    - MODE_PULSE: y high for exactly PULSE_WIDTH cycles (count 1..PULSE_WIDTH), then DONE.
    - MODE_LEVEL: y stays high until gamma_start.
  - DONE: y=0. Further edges are ignored for firing; at most one output spike per gamma cycle.
- spike_valid rises together with y; it and spike_time are held until gamma_start, which clears both the next cycle.
- gamma_start in any state (WAIT, FIRE, DONE):
  - Aborts the current activity: y=0 next cycle, pulse truncated, counter cleared.
  - Enters WAIT for the new cycle, evaluating all_in on that same cycle.
- No completion before phase saturates: remain in WAIT; no spike; spike_valid stays 0.
- in_mask changes mid-cycle take effect immediately on all_in. Dropping the last missing channel fires with the current phase.
- Elaboration asserts: PULSE_WIDTH>=1, N_INPUTS>=1, GAMMA_CYCLE_WIDTH>=2.

Decomposition:
- stc_pkg: out_mode_e {MODE_PULSE, MODE_LEVEL}; max_state_e {IDLE, WAIT, FIRE, DONE}; phase-width function clog2-based.
- Sub-module stc_arrival_latch, instantiated per channel: prev register, rise detect, gamma-cleared arrived flag.
- The top level holds the phase counter, the FSM and the pulse counter (width $clog2(PULSE_WIDTH)+1).

Test Plan:
- Pulse mode, mask=4'hF: gamma_start at t=0; rises on ch0..3 at phases 2,5,3,9 → y high at cycles 10..17 (8 cycles); spike_time=9; spike_valid=1 until next gamma_start.
- Same-cycle edges: all 4 rise at phase 0, coincident with gamma_start → spike_time=0; y high cycles 1..8. A level held high from the previous gamma cycle must not count.
- Mask: mask=4'b0101; ch0 at 3, ch2 at 6, ch1 never fires → spike_time=6. Mask=0 → y never asserts. Clearing the only missing bit at phase 7 → fire with spike_time=7.
- Abort: PULSE_WIDTH=8, fire at phase 12; gamma_start at phase 15 → y drops the next cycle (3-cycle pulse); new cycle arrivals accepted. A second rise on ch0 during DONE produces no second spike.
- Level mode: fire at phase 4 → y high from cycle 5 until the cycle after gamma_start. Missing input (ch3 never rises) → no spike; phase saturates at 15.
- grst asserted mid-FIRE, asynchronously → y, spike_valid, spike_time, busy go to 0 immediately; state IDLE; no firing until the next gamma_start.

Source files
------------

// File: rtl/stc_pkg.sv
// Shared types and helpers for the space-time computing (race logic) primitives.
package stc_pkg;

    typedef enum logic {
        MODE_PULSE,
        MODE_LEVEL
    } out_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FIRE,
        DONE
    } max_state_e;

    function automatic int unsigned phase_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/stc_arrival_latch.sv
// Per-channel spike arrival tracker: rising-edge detect plus a flag cleared by gamma_start.
module stc_arrival_latch (
    input  logic aclk,
    input  logic grst,
    input  logic gamma_start,
    input  logic a_i,
    output logic arrived_next_o
);

    logic prev_q;
    logic arrived_q;
    logic rise;

    // prev survives gamma_start so a level held across the boundary is not a new event
    assign rise           = a_i & ~prev_q;
    assign arrived_next_o = (gamma_start ? 1'b0 : arrived_q) | rise;

    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            prev_q    <= 1'b0;
            arrived_q <= 1'b0;
        end else begin
            prev_q    <= a_i;
            arrived_q <= arrived_next_o;
        end
    end

endmodule

// File: rtl/stc_max_n.sv
// N-input temporal MAX: fires once every enabled spike line has arrived in the gamma cycle,
// reporting the phase of the latest arrival.
module stc_max_n
    import stc_pkg::*;
#(
    parameter int unsigned N_INPUTS          = 4,
    parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
    parameter int unsigned PULSE_WIDTH       = 8,
    parameter out_mode_e   OUT_MODE          = MODE_PULSE
) (
    input  logic                                      aclk,
    input  logic                                      grst,
    input  logic                                      gamma_start,
    input  logic [N_INPUTS-1:0]                       in_mask,
    input  logic [N_INPUTS-1:0]                       a,
    output logic                                      y,
    output logic                                      spike_valid,
    output logic [phase_width(GAMMA_CYCLE_WIDTH)-1:0] spike_time,
    output logic                                      busy
);

    localparam int unsigned PHW = phase_width(GAMMA_CYCLE_WIDTH);
    localparam int unsigned CW  = $clog2(PULSE_WIDTH) + 1;
    localparam logic [PHW:0]  PH_MAX = (PHW + 1)'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [CW-1:0] PW_C   = CW'(PULSE_WIDTH);

    if (PULSE_WIDTH < 1 || N_INPUTS < 1 || GAMMA_CYCLE_WIDTH < 2) begin : g_param_check
        $error("stc_max_n: invalid parameter set");
    end

    max_state_e          state_q, state_d;
    logic [PHW-1:0]      phase_q, phase_d, cur_phase;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PHW-1:0]      spike_time_q, spike_time_d;
    logic                spike_valid_q, spike_valid_d;
    logic                y_q, y_d;
    logic [N_INPUTS-1:0] arrived_next;
    logic                all_in;
    logic                enter_fire;

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_ch
        stc_arrival_latch u_latch (
            .aclk           (aclk),
            .grst           (grst),
            .gamma_start    (gamma_start),
            .a_i            (a[i]),
            .arrived_next_o (arrived_next[i])
        );
    end

    assign cur_phase  = gamma_start ? '0 : phase_q;
    assign all_in     = (&(arrived_next | ~in_mask)) & (|in_mask);
    assign enter_fire = all_in & (gamma_start | (state_q == WAIT));

    always_comb begin
        phase_d = cur_phase + 1'b1;
        if (({1'b0, cur_phase} + 1'b1) >= PH_MAX) begin
            phase_d = PH_MAX[PHW-1:0];
        end
    end

    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            cnt_q         <= '0;
            spike_time_q  <= '0;
            spike_valid_q <= 1'b0;
            y_q           <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            cnt_q         <= cnt_d;
            spike_time_q  <= spike_time_d;
            spike_valid_q <= spike_valid_d;
            y_q           <= y_d;
        end
    end

    // gamma_start overrides every state: abort, then re-evaluate completion in the same cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (gamma_start) begin
            state_d = all_in ? FIRE : WAIT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                WAIT: if (all_in) state_d = FIRE;
                FIRE: begin
                    if (OUT_MODE == MODE_PULSE) begin
                        if (cnt_q == PW_C) state_d = DONE;
                        else               cnt_d   = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (enter_fire) cnt_d = CW'(1);

        y_d           = (state_d == FIRE);
        spike_valid_d = enter_fire | (spike_valid_q & ~gamma_start);
        spike_time_d  = enter_fire ? cur_phase : (gamma_start ? '0 : spike_time_q);
    end

    always_comb begin
        y           = y_q;
        spike_valid = spike_valid_q;
        spike_time  = spike_time_q;
        busy        = (state_q == WAIT);
    end

endmodule

// File: tb/tb_stc_max_n.sv
// Scoreboard bench: a pulse-mode and a level-mode instance share directed stimulus;
// each expected output spike (start cycle, time, length) is queued and checked on y falling.
module tb_stc_max_n;
    import stc_pkg::*;

    typedef struct {
        int start;
        int t;
        int len;
    } exp_t;

    logic       aclk        = 1'b0;
    logic       grst        = 1'b1;
    logic       gamma_start = 1'b0;
    logic [3:0] in_mask     = 4'hF;
    logic [3:0] a           = 4'h0;
    logic [1:0] y_w;
    logic [1:0] sv_w;
    logic [1:0] busy_w;
    logic [3:0] st_p, st_l;

    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   base    = 0;
    exp_t q_p[$];
    exp_t q_l[$];

    logic [1:0] y_prev = 2'b00;
    int         rise_cyc [2];
    int         rise_t   [2];
    int         rise_sv  [2];

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    stc_max_n #(
        .N_INPUTS(4), .GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .OUT_MODE(MODE_PULSE)
    ) u_pulse (
        .aclk(aclk), .grst(grst), .gamma_start(gamma_start), .in_mask(in_mask), .a(a),
        .y(y_w[0]), .spike_valid(sv_w[0]), .spike_time(st_p), .busy(busy_w[0])
    );

    stc_max_n #(
        .N_INPUTS(4), .GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .OUT_MODE(MODE_LEVEL)
    ) u_level (
        .aclk(aclk), .grst(grst), .gamma_start(gamma_start), .in_mask(in_mask), .a(a),
        .y(y_w[1]), .spike_valid(sv_w[1]), .spike_time(st_l), .busy(busy_w[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input int s, input int t, input int l);
        exp_t e;
        e.start = s;
        e.t     = t;
        e.len   = l;
        if (k == 0) q_p.push_back(e);
        else        q_l.push_back(e);
    endtask

    task automatic score(input int k, input int fall);
        exp_t  e;
        bit    have = 1'b0;
        string tag  = (k == 0) ? "pulse" : "level";
        if (k == 0 && q_p.size() > 0) begin e = q_p.pop_front(); have = 1'b1; end
        if (k == 1 && q_l.size() > 0) begin e = q_l.pop_front(); have = 1'b1; end
        if (!have) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_unexpected_spike: got spike at cycle %0d len %0d expected none",
                     tag, rise_cyc[k], fall - rise_cyc[k]);
        end else begin
            chk({tag, "_start"}, rise_cyc[k], e.start);
            chk({tag, "_time"},  rise_t[k],   e.t);
            chk({tag, "_len"},   fall - rise_cyc[k], e.len);
            chk({tag, "_valid"}, rise_sv[k],  1);
        end
    endtask

    always @(negedge aclk) begin
        for (int k = 0; k < 2; k++) begin
            if (y_w[k] && !y_prev[k]) begin
                rise_cyc[k] = cyc;
                rise_t[k]   = (k == 0) ? int'(st_p) : int'(st_l);
                rise_sv[k]  = int'(sv_w[k]);
            end else if (!y_w[k] && y_prev[k]) begin
                score(k, cyc);
            end
        end
        y_prev = y_w;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input int sv, input int st, input int bz);
        chk({tag, "_p_valid"}, int'(sv_w[0]), sv);
        chk({tag, "_l_valid"}, int'(sv_w[1]), sv);
        chk({tag, "_p_time"},  int'(st_p), st);
        chk({tag, "_l_time"},  int'(st_l), st);
        chk({tag, "_p_busy"},  int'(busy_w[0]), bz);
        chk({tag, "_l_busy"},  int'(busy_w[1]), bz);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge aclk);
        #1;
        chk("reset_p_y", int'(y_w[0]), 0);
        chk("reset_l_y", int'(y_w[1]), 0);
        chk_outs("reset", 0, 0, 0);
        grst = 1'b0;
        repeat (3) tick();

        // S1: basic, arrivals at phases 2,5,3,9 -> time 9
        base = cyc;
        push(0, base + 10, 9, 8);
        push(1, base + 10, 9, 11);
        for (int o = 0; o < 20; o++) begin
            gamma_start = (o == 0);
            if (o == 2) a[0] = 1'b1;
            if (o == 3) a[2] = 1'b1;
            if (o == 5) a[1] = 1'b1;
            if (o == 9) a[3] = 1'b1;
            if (o == 19) begin
                chk("s1_p_valid_held", int'(sv_w[0]), 1);
                chk("s1_p_time_held",  int'(st_p), 9);
                chk("s1_p_busy_done",  int'(busy_w[0]), 0);
            end
            tick();
        end

        // S2: inputs held high across gamma_start are not new events
        for (int o = 0; o < 20; o++) begin
            gamma_start = (o == 0);
            if (o == 1)  chk("s2_p_valid_cleared", int'(sv_w[0]), 0);
            if (o == 17) a = 4'h0;
            if (o == 19) chk_outs("s2_idle_wait", 0, 0, 1);
            tick();
        end

        // S3: all edges coincide with gamma_start -> time 0
        base = cyc;
        push(0, base + 1, 0, 8);
        push(1, base + 1, 0, 20);
        for (int o = 0; o < 20; o++) begin
            gamma_start = (o == 0);
            if (o == 0)  a = 4'hF;
            if (o == 10) a = 4'h0;
            tick();
        end

        // S4: mask 0101, ch0 at 3, ch2 at 6 -> time 6
        base = cyc;
        push(0, base + 7, 6, 8);
        push(1, base + 7, 6, 14);
        for (int o = 0; o < 20; o++) begin
            gamma_start = (o == 0);
            if (o == 0)  in_mask = 4'b0101;
            if (o == 3)  a[0] = 1'b1;
            if (o == 6)  a[2] = 1'b1;
            if (o == 17) a = 4'h0;
            tick();
        end

        // S5: mask 0 never fires
        for (int o = 0; o < 20; o++) begin
            gamma_start = (o == 0);
            if (o == 0)  in_mask = 4'h0;
            if (o == 2)  a = 4'hF;
            if (o == 17) a = 4'h0;
            if (o == 19) chk_outs("s5_mask0", 0, 0, 1);
            tick();
        end

        // S6: dropping the missing channel from the mask at phase 7 fires
        base = cyc;
        push(0, base + 8, 7, 8);
        push(1, base + 8, 7, 13);
        for (int o = 0; o < 20; o++) begin
            gamma_start = (o == 0);
            if (o == 0)  in_mask = 4'hF;
            if (o == 1)  a = 4'b0111;
            if (o == 7)  in_mask = 4'b0111;
            if (o == 17) begin a = 4'h0; in_mask = 4'hF; end
            tick();
        end

        // S7: fire at phase 12, gamma_start at phase 15 truncates to 3 cycles
        base = cyc;
        push(0, base + 13, 12, 3);
        push(1, base + 13, 12, 3);
        for (int o = 0; o < 15; o++) begin
            gamma_start = (o == 0);
            if (o == 10) a[0] = 1'b1;
            if (o == 12) a = 4'hF;
            if (o == 14) a = 4'h0;
            tick();
        end

        // S8: new cycle accepts arrivals; re-rise on ch0 during DONE is ignored
        base = cyc;
        push(0, base + 5, 4, 8);
        push(1, base + 5, 4, 16);
        for (int o = 0; o < 20; o++) begin
            gamma_start = (o == 0);
            if (o == 4)  a = 4'hF;
            if (o == 14) a[0] = 1'b0;
            if (o == 15) a[0] = 1'b1;
            if (o == 17) a = 4'h0;
            tick();
        end

        // S9: ch3 never arrives -> no spike, stays in WAIT
        for (int o = 0; o < 20; o++) begin
            gamma_start = (o == 0);
            if (o == 3)  a = 4'b0111;
            if (o == 17) a = 4'h0;
            if (o == 19) chk_outs("s9_missing", 0, 0, 1);
            tick();
        end

        // S10: asynchronous reset in the middle of FIRE
        base = cyc;
        push(0, base + 1, 0, 3);
        push(1, base + 1, 0, 3);
        for (int o = 0; o < 25; o++) begin
            gamma_start = (o == 0);
            if (o == 0) a = 4'hF;
            if (o == 4) begin
                #2;
                grst = 1'b1;
                #1;
                chk("rst_p_y", int'(y_w[0]), 0);
                chk("rst_l_y", int'(y_w[1]), 0);
                chk_outs("rst_async", 0, 0, 0);
            end
            if (o == 7)  grst = 1'b0;
            if (o == 8)  a = 4'h0;
            if (o == 10) a = 4'hF;
            if (o == 24) chk_outs("post_rst_idle", 0, 0, 0);
            tick();
        end

        a = 4'h0;
        repeat (5) tick();
        chk("pulse_queue_empty", q_p.size(), 0);
        chk("level_queue_empty", q_l.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
